arb_rr: RTL and testbench
=========================

Name: arb_rr

Overview:
- Parametrised N-way bus arbiter with registered grant.
- Successor to the combinational 7-input priority encoder.
- Adds the following over the encoder:
  - grant tenure: the winner holds the grant until it releases;
  - selectable fixed-priority or round-robin mode;
  - an optional tenure limit that preempts a long-held grant.
- Sits ahead of the 8-bit bus drivers; v and g drive their enables directly.

Parameters:
- N, 7, number of requesters, numbered 1..N (N >= 2).
- MODE, 0, 0 = fixed priority (lowest number wins), 1 = round-robin.
- TMAX, 0, maximum grant tenure in cycles; 0 disables preemption.

Ports:
- c  input  1  clock, rising edge.
- r  input  1  reset, asynchronous, active-high.
- e  input  1  enable; low freezes all state.
- a  input  [N:1]  request vector; a[i] high = requester i wants the bus.
- y  output  [W-1:0]  encoded grantee, W = clog2(N+1); 0 = none.
- g  output  [N:1]  one-hot grant; all zero when none.
- v  output  1  grant valid; v = |g.

Behaviour:
- Reset (r=1, asynchronous, immediate):
  - y=0, g=0, v=0, tenure counter t=0, last-grantee pointer p=N.
  - All outputs are registered; no combinational path from a to any output.
- Arbitration function pick(a, start, excl):
  - Scans indices start, start+1, ..., N, 1, ..., start-1.
  - Returns the first i with a[i]=1 and i != excl; returns 0 if none.
  - Fixed mode: start = 1.
  - Round-robin mode: start = p+1, wrapping N -> 1.
- Rising edge of c with e=1, evaluated in this order:
  1. v=0:
     - w = pick(a, start, 0).
     - If w != 0: grant w, set t=1, p=w.
     - Otherwise remain idle.
  2. v=1 and a[y]=0 (release):
     - w = pick(a, start, 0).
     - Zero-bubble handover: the new grant is visible on the cycle immediately after the release edge.
     - If w=0: go to y=0, v=0, t=0.
  3. v=1, a[y]=1, TMAX != 0, t = TMAX, and some other a[i]=1 (preempt):
     - w = pick(a, start, y).
     - Grant w, set t=1, p=w.
  4. v=1, otherwise (hold):
     - Grant unchanged.
     - t increments, saturating at TMAX; if TMAX = 0, t stays at 1.
- Holding time: with TMAX=k, a contested holder keeps the grant for exactly k cycles.
- Release and limit on the same edge: release (case 2) wins; the outcome is identical either way.
- A lone requester is never preempted; t saturates and the grant persists.
- p updates only on a new grant. It is tracked in fixed mode too but has no effect there.
- e=0:
  - y, g, v, t and p hold, regardless of a.
  - When e returns high, arbitration resumes on the next edge using the current a.
- Reset asserted mid-tenure: clears immediately. After deassertion the first grant follows reset rules (p=N, so the search starts at 1).
- Request changes between edges are only sampled at the edge.
- g is always one-hot or zero. y and g always agree.

Decomposition:
- Package arb_pkg holds:
  - constants ARB_FIXED=0 and ARB_RR=1;
  - a clog2 constant function used to size W and the t counter (clog2(TMAX+1), minimum 1 bit).
- One natural sub-module: arb_pick.
  - Combinational, parametrised by N.
  - Inputs: a, start, excl. Output: w.
  - Implemented as a rotate-and-find-first over the request vector.
- The top level contains the registers, the tenure counter and the case 1–4 control.

Test Plan (N=7):
1. Reset:
   - Drive r=1 between edges with v=1, y=4.
   - -> y=0, g=0, v=0 immediately, before the next edge.
   - After release of r, with a=7'b1111111 (RR mode) -> first grant y=1.
2. Fixed mode, TMAX=0, a[3] and a[5] high:
   - -> y=3, g=7'b0000100 on the next edge.
   - Held for 20 cycles while a[3] stays high.
   - Drop a[3] -> y=5 on the next edge, no idle cycle.
   - Drop a[5] -> y=0, v=0.
3. RR mode, TMAX=4, a=7'b1111111 held constant:
   - -> y sequence 1,2,3,4,5,6,7,1, each value for exactly 4 cycles.
4. RR mode, TMAX=4, only a[6] high for 12 cycles:
   - -> y=6 throughout, no preemption.
   - Raise a[2] at cycle 12 -> y=2 on the next edge (t already saturated at 4).
5. Enable freeze:
   - With y=2, set e=0 and drop a[2] for 5 cycles -> y stays 2, v=1.
   - Set e=1 with a[4] high -> y=4 on the next edge.
6. RR fairness after release:
   - Grant at 6; drop a[6] with a[1] and a[7] high -> y=7, not 1.
   - Release 7 -> y=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and sizing helpers for the round-robin / fixed-priority arbiter.
package arb_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Smallest b with 2**b >= x, never less than 1 bit.
    function automatic int unsigned clog2(input int unsigned x);
        int unsigned b;
        b = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(x)) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/arb_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arb_rr_if #(
    parameter int unsigned N = 7
) ();
    import arb_pkg::*;

    localparam int unsigned W = clog2(N + 1);

    logic         e;   // enable; low freezes the arbiter
    logic [N:1]   a;   // request vector
    logic [W-1:0] y;   // encoded grantee, 0 = none
    logic [N:1]   g;   // one-hot grant
    logic         v;   // grant valid

    modport master (output e, a, input y, g, v);
    modport slave  (input e, a, output y, g, v);

endinterface

// File: rtl/arb_pick.sv
// Circular find-first: first requester at or after start (wrapping N -> 1), skipping excl.
module arb_pick import arb_pkg::*; #(
    parameter int unsigned N = 7,
    parameter int unsigned W = clog2(N + 1)
) (
    input  logic [N:1]   a,
    input  logic [W-1:0] start,
    input  logic [W-1:0] excl,
    output logic [W-1:0] w
);

    logic [N-1:0]   req;
    logic [2*N-1:0] rot;

    // Mask out the excluded index; bit i-1 of req stands for requester i.
    always_comb begin
        req = '0;
        for (int i = 1; i <= N; i++) begin
            req[i-1] = a[i] && (excl != W'(i));
        end
    end

    // Rotate so that start lands at bit 0, then take the lowest set bit and map it back.
    always_comb begin
        int unsigned base;
        int unsigned idx;
        base = (start == '0) ? 0 : 32'(start) - 1;
        idx  = 0;
        rot  = {req, req} >> base;
        w    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = base + unsigned'(k);
                if (idx >= N) begin
                    idx = idx - N;
                end
                w = W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/arb_rr.sv
// N-way bus arbiter with registered grant, grant tenure and optional tenure-limit preemption.
module arb_rr import arb_pkg::*; #(
    parameter int unsigned N    = 7,
    parameter int unsigned MODE = ARB_FIXED,
    parameter int unsigned TMAX = 0
) (
    input  logic     c,
    input  logic     r,
    arb_rr_if.slave  bus
);

    localparam int unsigned W  = clog2(N + 1);
    localparam int unsigned TW = clog2(TMAX + 1);

    localparam logic [W-1:0]  PN   = W'(N);
    localparam logic [TW-1:0] TLIM = TW'(TMAX);

    logic [W-1:0]  y_q, y_d;
    logic [W-1:0]  p_q, p_d;
    logic [N:1]    g_q, g_d;
    logic          v_q, v_d;
    logic [TW-1:0] t_q, t_d;

    logic [W-1:0]  start;
    logic [W-1:0]  excl;
    logic [W-1:0]  w;
    logic [N:1]    g_w;
    logic          held;

    // Search origin: always 1 in fixed mode, one past the last grantee in round-robin mode.
    always_comb begin
        if (MODE == ARB_RR) begin
            start = (p_q == PN) ? W'(1) : p_q + W'(1);
        end else begin
            start = W'(1);
        end
    end

    // The current holder still requesting; only then is it excluded from the search (preempt).
    assign held = |(bus.a & g_q);
    assign excl = held ? y_q : '0;

    arb_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .a     (bus.a),
        .start (start),
        .excl  (excl),
        .w     (w)
    );

    // One-hot form of the picked winner.
    always_comb begin
        g_w = '0;
        for (int i = 1; i <= N; i++) begin
            g_w[i] = (w == W'(i));
        end
    end

    // Next-state: idle grant, release handover, tenure-limit preempt, or hold.
    always_comb begin
        y_d = y_q;
        g_d = g_q;
        v_d = v_q;
        t_d = t_q;
        p_d = p_q;
        if (bus.e) begin
            if (!v_q || !held) begin
                // Idle or released: hand over with no bubble, or fall idle.
                if (w != '0) begin
                    y_d = w;
                    g_d = g_w;
                    v_d = 1'b1;
                    t_d = TW'(1);
                    p_d = w;
                end else begin
                    y_d = '0;
                    g_d = '0;
                    v_d = 1'b0;
                    t_d = '0;
                end
            end else if ((TMAX != 0) && (t_q == TLIM) && (w != '0)) begin
                // Tenure exhausted and someone else waiting.
                y_d = w;
                g_d = g_w;
                v_d = 1'b1;
                t_d = TW'(1);
                p_d = w;
            end else if (TMAX == 0) begin
                t_d = TW'(1);
            end else if (t_q != TLIM) begin
                t_d = t_q + TW'(1);
            end
        end
    end

    // State registers; reset leaves the pointer at N so the first search starts at 1.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            y_q <= '0;
            g_q <= '0;
            v_q <= 1'b0;
            t_q <= '0;
            p_q <= PN;
        end else begin
            y_q <= y_d;
            g_q <= g_d;
            v_q <= v_d;
            t_q <= t_d;
            p_q <= p_d;
        end
    end

    assign bus.y = y_q;
    assign bus.g = g_q;
    assign bus.v = v_q;

    // Grant is one-hot or zero and agrees with the encoded grantee.
    always_ff @(posedge c) begin
        if (!r) begin
            assert ($onehot0(g_q));
            assert (v_q == (|g_q));
            assert (g_q == ((y_q == '0) ? '0 : (N'(1) << (y_q - W'(1)))));
        end
    end

endmodule

// File: tb/tb_arb_rr.sv
// Bench for arb_rr: a fixed/TMAX=0 and a round-robin/TMAX=4 instance share one stimulus.
module tb_arb_rr;
    import arb_pkg::*;

    localparam int N = 7;

    typedef struct {
        int y;
        int t;
        int p;
    } mst_t;

    logic       c = 1'b0;
    logic       r = 1'b1;
    logic       e_s = 1'b1;
    logic [N:1] a_s = '0;

    int checks = 0;
    int errs   = 0;

    mst_t m_fx = '{0, 0, N};
    mst_t m_rr = '{0, 0, N};

    arb_rr_if #(.N(N)) bus_fx ();
    arb_rr_if #(.N(N)) bus_rr ();

    assign bus_fx.e = e_s;
    assign bus_fx.a = a_s;
    assign bus_rr.e = e_s;
    assign bus_rr.a = a_s;

    arb_rr #(.N(N), .MODE(ARB_FIXED), .TMAX(0)) u_fx (.c(c), .r(r), .bus(bus_fx));
    arb_rr #(.N(N), .MODE(ARB_RR),    .TMAX(4)) u_rr (.c(c), .r(r), .bus(bus_rr));

    always #5 c = ~c;

    // Scan start, start+1, .., N, 1, .., start-1 for a requester other than ex.
    function automatic int pick(input logic [N:1] a, input int st, input int ex);
        for (int k = 0; k < N; k++) begin
            int i;
            i = ((st - 1 + k) % N) + 1;
            if (a[i] && i != ex) return i;
        end
        return 0;
    endfunction

    function automatic mst_t step(input mst_t s, input logic [N:1] a, input logic en,
                                  input int mode, input int tmax);
        mst_t n;
        int   st;
        int   w;
        n = s;
        if (!en) return s;
        st = (mode == 1) ? (s.p % N) + 1 : 1;
        if (s.y == 0 || !a[s.y]) begin
            w = pick(a, st, 0);
            if (w != 0) begin
                n.y = w; n.t = 1; n.p = w;
            end else begin
                n.y = 0; n.t = 0;
            end
        end else begin
            w = pick(a, st, s.y);
            if (tmax != 0 && s.t == tmax && w != 0) begin
                n.y = w; n.t = 1; n.p = w;
            end else begin
                n.t = (tmax == 0) ? 1 : ((s.t < tmax) ? s.t + 1 : tmax);
            end
        end
        return n;
    endfunction

    function automatic int gof(input int y);
        return (y == 0) ? 0 : (1 << (y - 1));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // Reference model.
    always @(posedge c or posedge r) begin
        if (r) begin
            m_fx <= '{0, 0, N};
            m_rr <= '{0, 0, N};
        end else begin
            m_fx <= step(m_fx, a_s, e_s, 0, 0);
            m_rr <= step(m_rr, a_s, e_s, 1, 4);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge c) begin
        chk("fx_y", int'(bus_fx.y), m_fx.y);
        chk("fx_g", int'(bus_fx.g), gof(m_fx.y));
        chk("fx_v", int'(bus_fx.v), int'(m_fx.y != 0));
        chk("rr_y", int'(bus_rr.y), m_rr.y);
        chk("rr_g", int'(bus_rr.g), gof(m_rr.y));
        chk("rr_v", int'(bus_rr.v), int'(m_rr.y != 0));
    end

    initial begin
        tick();
        tick();
        chk("rst_fx_y", int'(bus_fx.y), 0);
        chk("rst_rr_v", int'(bus_rr.v), 0);
        r = 1'b0;

        // Fixed priority with no tenure limit.
        a_s = 7'b0010100;
        tick();
        chk("fx_first_y", int'(bus_fx.y), 3);
        chk("fx_first_g", int'(bus_fx.g), 7'b0000100);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("fx_hold3", int'(bus_fx.y), 3);
        end
        a_s = 7'b0010000;
        tick();
        chk("fx_handover5", int'(bus_fx.y), 5);
        chk("fx_handover_v", int'(bus_fx.v), 1);
        a_s = 7'b0000000;
        tick();
        chk("fx_idle_y", int'(bus_fx.y), 0);
        chk("fx_idle_v", int'(bus_fx.v), 0);

        // Asynchronous reset mid-tenure.
        a_s = 7'b0001000;
        tick();
        chk("rr_pre_rst_y", int'(bus_rr.y), 4);
        r = 1'b1;
        #1;
        chk("async_rst_y", int'(bus_rr.y), 0);
        chk("async_rst_g", int'(bus_rr.g), 0);
        chk("async_rst_v", int'(bus_rr.v), 0);
        chk("async_rst_fx_y", int'(bus_fx.y), 0);
        @(posedge c);
        #1;
        a_s = 7'b1111111;
        #2;
        r = 1'b0;

        // Round-robin rotation under the tenure limit.
        tick();
        chk("rr_after_rst_y", int'(bus_rr.y), 1);
        for (int k = 1; k < 32; k++) begin
            tick();
            chk("rr_rotate", int'(bus_rr.y), ((k / 4) % 7) + 1);
        end

        // Lone requester is never preempted; a newcomer wins once tenure is saturated.
        a_s = 7'b0100000;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rr_lone6", int'(bus_rr.y), 6);
        end
        a_s = 7'b0100010;
        tick();
        chk("rr_preempt2", int'(bus_rr.y), 2);

        // Enable freeze.
        e_s = 1'b0;
        a_s = 7'b0000000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("freeze_y", int'(bus_rr.y), 2);
            chk("freeze_v", int'(bus_rr.v), 1);
        end
        e_s = 1'b1;
        a_s = 7'b0001000;
        tick();
        chk("unfreeze_y", int'(bus_rr.y), 4);

        // Fairness after release.
        a_s = 7'b0100000;
        tick();
        chk("fair_6", int'(bus_rr.y), 6);
        a_s = 7'b1000001;
        tick();
        chk("fair_7", int'(bus_rr.y), 7);
        a_s = 7'b0000001;
        tick();
        chk("fair_1", int'(bus_rr.y), 1);

        // Randomised traffic with sticky requests, enable gaps and rare resets.
        for (int k = 0; k < 600; k++) begin
            a_s = a_s ^ 7'($urandom & $urandom);
            e_s = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) begin
                r = 1'b1;
                #2;
                r = 1'b0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
